// File: rtl/dma_issue_queue.sv
// DMA instruction issue queue: FIFO of {we, addr, cache_addr, dat} with a two-state issue FSM
// that inserts a guard cycle between issues. Optional stall counter under DMA_QUEUE_PERF_EN.
module dma_issue_queue #(
  parameter int DEPTH        = 4,
  parameter int CACHE_ADDR_W = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_we,
  input  logic [6:0]              in_addr,
  input  logic [CACHE_ADDR_W-1:0] in_cache_addr,
  input  logic [17:0]             in_dat,
  input  logic                    flush,
  input  logic                    dma_busy,
  output logic                    out_valid,
  output logic                    out_we,
  output logic [6:0]              out_addr,
  output logic [CACHE_ADDR_W-1:0] out_cache_addr,
  output logic [17:0]             out_dat,
  output logic                    idle,
  output logic [15:0]             stall_cnt
);

  localparam int CW = $clog2(DEPTH);
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  typedef struct packed {
    logic                    we;
    logic [6:0]              addr;
    logic [CACHE_ADDR_W-1:0] cache_addr;
    logic [17:0]             dat;
  } entry_t;

  typedef enum logic {ISSUE_IDLE, ISSUE_GUARD} state_t;

  entry_t          mem [DEPTH];
  entry_t          in_ent;
  entry_t          out_q;
  logic [CW-1:0]   wr_ptr, rd_ptr;
  logic [CW:0]     count;
  state_t          state;
  logic            push, pop;

  assign in_ent   = '{we: in_we, addr: in_addr, cache_addr: in_cache_addr, dat: in_dat};
  assign in_ready = (count < DEPTH_C);
  assign push     = in_valid && in_ready && !flush;
  assign pop      = (state == ISSUE_IDLE) && (count != '0) && !dma_busy && !flush;

  // Storage needs no reset: entries are only read when count says they are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_ent;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Guard cycle lets the engine's registered busy become visible before the next issue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ISSUE_IDLE;
      out_valid <= 1'b0;
      out_q     <= '0;
    end else begin
      case (state)
        ISSUE_IDLE: begin
          if (pop) begin
            out_valid <= 1'b1;
            out_q     <= mem[rd_ptr];
            state     <= ISSUE_GUARD;
          end else begin
            out_valid <= 1'b0;
          end
        end
        ISSUE_GUARD: begin
          out_valid <= 1'b0;
          state     <= ISSUE_IDLE;
        end
        default: begin
          out_valid <= 1'b0;
          state     <= ISSUE_IDLE;
        end
      endcase
    end
  end

  assign out_we         = out_q.we;
  assign out_addr       = out_q.addr;
  assign out_cache_addr = out_q.cache_addr;
  assign out_dat        = out_q.dat;

  assign idle = (count == '0) && (state == ISSUE_IDLE) && !out_valid && !dma_busy;

`ifdef DMA_QUEUE_PERF_EN
  logic [15:0] stall_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
    end else if ((count != '0) && (state == ISSUE_IDLE) && dma_busy && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 1'b1;
    end
  end
  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_dma_issue_queue.sv
// Directed bench for dma_issue_queue; inputs driven and outputs sampled on the falling edge.
module tb_dma_issue_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_we = 1'b0;
  logic [6:0]  in_addr = '0;
  logic [7:0]  in_cache_addr = '0;
  logic [17:0] in_dat = '0;
  logic        flush = 1'b0;
  logic        dma_busy = 1'b0;
  logic        out_valid;
  logic        out_we;
  logic [6:0]  out_addr;
  logic [7:0]  out_cache_addr;
  logic [17:0] out_dat;
  logic        idle;
  logic [15:0] stall_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dma_issue_queue #(.DEPTH(4), .CACHE_ADDR_W(8)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_we(in_we), .in_addr(in_addr),
    .in_cache_addr(in_cache_addr), .in_dat(in_dat),
    .flush(flush), .dma_busy(dma_busy),
    .out_valid(out_valid), .out_we(out_we), .out_addr(out_addr),
    .out_cache_addr(out_cache_addr), .out_dat(out_dat),
    .idle(idle), .stall_cnt(stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic we, input logic [6:0] a,
                       input logic [7:0] ca, input logic [17:0] d);
    in_valid = v; in_we = we; in_addr = a; in_cache_addr = ca; in_dat = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; drive(0, 0, 0, 0, 0); flush = 0; dma_busy = 0;
    tick();
    reset = 1'b0;
  endtask

  logic [15:0] exp_stall;

  initial begin
    // reset state
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_idle", 32'(idle), 1);
    chk("rst_out_addr", 32'(out_addr), 0);
    chk("rst_stall", 32'(stall_cnt), 0);
    reset = 1'b0;
    tick();

    // single write: push edge, issue edge, then guard
    drive(1, 1, 7'h15, 8'h3C, 18'h1A2B4);
    tick();
    drive(0, 0, 0, 0, 0);
    chk("one_pre_valid", 32'(out_valid), 0);
    chk("one_pre_idle", 32'(idle), 0);
    tick();
    chk("one_valid", 32'(out_valid), 1);
    chk("one_we", 32'(out_we), 1);
    chk("one_addr", 32'(out_addr), 32'h15);
    chk("one_caddr", 32'(out_cache_addr), 32'h3C);
    chk("one_dat", 32'(out_dat), 32'h1A2B4);
    tick();
    chk("one_pulse_end", 32'(out_valid), 0);
    chk("one_hold_addr", 32'(out_addr), 32'h15);
    chk("one_idle", 32'(idle), 1);

    // fill with busy held, 5th push rejected, then drain in order
    dma_busy = 1;
    for (int i = 1; i <= 4; i++) begin
      drive(1, 0, 7'(i), 8'(i + 8'h10), 18'(i * 18'h111));
      tick();
    end
    chk("full_in_ready", 32'(in_ready), 0);
    drive(1, 0, 7'h55, 8'h55, 18'h55);
    tick();
    drive(0, 0, 0, 0, 0);
    chk("full_no_issue", 32'(out_valid), 0);
    dma_busy = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("drain_valid_%0d", i), 32'(out_valid), (i % 2 == 0) ? 1 : 0);
      if (i % 2 == 0) begin
        chk($sformatf("drain_addr_%0d", i), 32'(out_addr), i / 2 + 1);
        chk($sformatf("drain_dat_%0d", i), 32'(out_dat), (i / 2 + 1) * 32'h111);
      end
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("drain_extra_%0d", i), 32'(out_valid), 0);
    end
    chk("drain_idle", 32'(idle), 1);

    // engine busy for 20 cycles after an issue blocks the next one
    dma_busy = 1;
    drive(1, 0, 7'h21, 8'h01, 18'h00AAA); tick();
    drive(1, 1, 7'h22, 8'h02, 18'h00BBB); tick();
    drive(0, 0, 0, 0, 0);
    dma_busy = 0;
    tick();
    chk("eng_first_valid", 32'(out_valid), 1);
    chk("eng_first_addr", 32'(out_addr), 32'h21);
    dma_busy = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("eng_busy_%0d", i), 32'(out_valid), 0);
    end
    dma_busy = 0;
    tick();
    chk("eng_second_valid", 32'(out_valid), 1);
    chk("eng_second_addr", 32'(out_addr), 32'h22);
    chk("eng_second_we", 32'(out_we), 1);
    tick();

    // flush with 3 queued and a simultaneous push
    dma_busy = 1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 7'(8'h30 + i), 8'h00, 18'h0); tick();
    end
    drive(1, 0, 7'h3F, 8'h00, 18'h0);
    flush = 1; dma_busy = 0;
    tick();
    flush = 0; drive(0, 0, 0, 0, 0);
    chk("flush_idle", 32'(idle), 1);
    chk("flush_in_ready", 32'(in_ready), 1);
    chk("flush_no_issue", 32'(out_valid), 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("flush_quiet_%0d", i), 32'(out_valid), 0);
    end

    // asynchronous reset while out_valid is high
    drive(1, 1, 7'h44, 8'h44, 18'h3FFFF); tick();
    drive(0, 0, 0, 0, 0);
    tick();
    chk("arst_pre_valid", 32'(out_valid), 1);
    #1 reset = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_in_ready", 32'(in_ready), 1);
    chk("arst_addr", 32'(out_addr), 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("arst_quiet_%0d", i), 32'(out_valid), 0);
    end
    chk("arst_idle", 32'(idle), 1);

    // stall counter: 2 queued, busy edges counted while count>0
    do_reset();
    chk("perf_rst", 32'(stall_cnt), 0);
    dma_busy = 1;
    drive(1, 0, 7'h01, 8'h0, 18'h0); tick();
    drive(1, 0, 7'h02, 8'h0, 18'h0); tick();
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) tick();
    dma_busy = 0;
`ifdef DMA_QUEUE_PERF_EN
    exp_stall = 16'd10;
`else
    exp_stall = 16'd0;
`endif
    chk("perf_stall10", 32'(stall_cnt), 32'(exp_stall));
    for (int i = 0; i < 5; i++) tick();
    chk("perf_hold", 32'(stall_cnt), 32'(exp_stall));
    chk("perf_drained_idle", 32'(idle), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
